// File: rtl/flow_key_extractor.sv
// flow_key_extractor
//   Parses an AXI4-Stream Ethernet frame (DATA_W = 8/32/64), optionally skips
//   one 802.1Q tag, and extracts the IPv4 5-tuple into a 104-bit flow key with
//   a 16-bit fold hash and status flags. Acts as a frame sink and keeps
//   per-class frame counters.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   s_axis_*        : input frame stream (first byte on tdata[7:0])
//   m_key           : {src_ip, dst_ip, src_port, dst_port, proto}
//   m_hash          : XOR of the seven 16-bit words of {8'h00, m_key}
//   m_flags         : [0] ipv4, [1] ports valid, [2] vlan, [3] truncated
//   m_key_valid/ready : output slot handshake
//   stat_*          : frame / non-IP / truncated counters (wrap at 2^32)
module flow_key_extractor #(
  parameter int unsigned DATA_W  = 32,
  parameter bit          VLAN_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic [DATA_W/8-1:0] s_axis_tkeep,
  input  logic                s_axis_tvalid,
  input  logic                s_axis_tlast,
  output logic                s_axis_tready,
  output logic [103:0]        m_key,
  output logic [15:0]         m_hash,
  output logic [3:0]          m_flags,
  output logic                m_key_valid,
  input  logic                m_key_ready,
  output logic [31:0]         stat_frames,
  output logic [31:0]         stat_non_ip,
  output logic [31:0]         stat_trunc
);

  localparam int unsigned NB      = DATA_W / 8;
  localparam int unsigned HDR_N   = 26;      // header bytes 12..37 are kept
  localparam logic [7:0]  HDR_LO  = 8'd12;
  localparam logic [7:0]  HDR_HI  = 8'd38;
  localparam logic [7:0]  OFF_MAX = 8'd127;

  typedef enum logic {
    IDLE,
    PARSE
  } state_e;

  state_e                 state_q;
  logic [6:0]             off_q;
  logic [HDR_N-1:0][7:0]  hdr_q, hdr_d;
  logic [31:0]            ports_q, ports_d;
  logic [103:0]           key_q, key_d;
  logic [15:0]            hash_q, hash_d;
  logic [3:0]             flags_q, flags_d;
  logic                   valid_q;
  logic [31:0]            frames_q, non_ip_q, trunc_q;

  logic                   beat_ok, last_ok, frame_start;
  logic [6:0]             base, cnt_d;
  logic [7:0]             nbytes, sum;
  logic [7:0]             hlane_off, plane_off, rel;
  logic                   vlan;
  logic [4:0]             lb;
  logic [7:0]             l3_off, p_off, vi, proto;
  logic [15:0]            ethertype;
  logic [12:0]            frag_off;
  logic [31:0]            src_ip, dst_ip;
  logic                   is_ip, is_trunc, ports_ok;
  logic [111:0]           hash_src;

  // A new frame's first beat waits while the slot is full and not draining.
  assign s_axis_tready = !(state_q == IDLE && valid_q && !m_key_ready);
  assign beat_ok       = s_axis_tvalid && s_axis_tready;
  assign last_ok       = beat_ok && s_axis_tlast;
  assign frame_start   = (state_q == IDLE);
  assign base          = frame_start ? '0 : off_q;

  // Bytes received so far including this beat, saturating at 127.
  always_comb begin
    nbytes = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      nbytes = nbytes + {7'd0, s_axis_tkeep[i]};
    end
    sum   = {1'b0, base} + nbytes;
    cnt_d = (sum > OFF_MAX) ? 7'd127 : sum[6:0];
  end

  // Header bytes are stored by absolute offset; fields are then picked from
  // the merged view so that a field completed on the tlast beat is usable.
  always_comb begin
    hdr_d     = frame_start ? '0 : hdr_q;
    hlane_off = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      hlane_off = {1'b0, base} + 8'(i);
      if (beat_ok && s_axis_tkeep[i] && hlane_off >= HDR_LO && hlane_off < HDR_HI) begin
        hdr_d[5'(hlane_off - HDR_LO)] = s_axis_tdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    vlan      = VLAN_EN && hdr_d[0] == 8'h81 && hdr_d[1] == 8'h00;
    lb        = vlan ? 5'd6 : 5'd2;          // L3 base relative to byte 12
    l3_off    = vlan ? 8'd18 : 8'd14;
    ethertype = {hdr_d[lb - 5'd2], hdr_d[lb - 5'd1]};
    vi        = hdr_d[lb];
    frag_off  = {hdr_d[lb + 5'd6][4:0], hdr_d[lb + 5'd7]};
    proto     = hdr_d[lb + 5'd9];
    src_ip    = {hdr_d[lb + 5'd12], hdr_d[lb + 5'd13], hdr_d[lb + 5'd14], hdr_d[lb + 5'd15]};
    dst_ip    = {hdr_d[lb + 5'd16], hdr_d[lb + 5'd17], hdr_d[lb + 5'd18], hdr_d[lb + 5'd19]};
    p_off     = l3_off + {2'b00, vi[3:0], 2'b00};
  end

  // Port bytes: earlier speculative captures (before IHL is known) are always
  // overwritten by the real P..P+3 bytes, which lie beyond the IP header.
  always_comb begin
    ports_d   = frame_start ? '0 : ports_q;
    plane_off = '0;
    rel       = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      plane_off = {1'b0, base} + 8'(i);
      rel       = plane_off - p_off;
      if (beat_ok && s_axis_tkeep[i] && plane_off < OFF_MAX &&
          plane_off >= p_off && rel < 8'd4) begin
        case (rel[1:0])
          2'd0:    ports_d[31:24] = s_axis_tdata[8*i +: 8];
          2'd1:    ports_d[23:16] = s_axis_tdata[8*i +: 8];
          2'd2:    ports_d[15:8]  = s_axis_tdata[8*i +: 8];
          default: ports_d[7:0]   = s_axis_tdata[8*i +: 8];
        endcase
      end
    end
  end

  always_comb begin
    is_ip    = ethertype == 16'h0800 && vi[7:4] == 4'd4;
    is_trunc = vi[3:0] < 4'd5 || {1'b0, cnt_d} < l3_off + 8'd20;
    ports_ok = (proto == 8'd6 || proto == 8'd17) && frag_off == '0 &&
               {1'b0, cnt_d} >= p_off + 8'd4;
    key_d      = '0;
    flags_d    = '0;
    flags_d[2] = vlan;
    if (is_ip) begin
      flags_d[0] = 1'b1;
      if (is_trunc) begin
        flags_d[3] = 1'b1;
      end else begin
        flags_d[1] = ports_ok;
        key_d      = {src_ip, dst_ip, (ports_ok ? ports_d : 32'h0), proto};
      end
    end
    hash_src = {8'h00, key_d};
    hash_d   = '0;
    for (int unsigned w = 0; w < 7; w++) begin
      hash_d = hash_d ^ hash_src[16*w +: 16];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      off_q    <= '0;
      hdr_q    <= '0;
      ports_q  <= '0;
      valid_q  <= 1'b0;
      key_q    <= '0;
      hash_q   <= '0;
      flags_q  <= '0;
      frames_q <= '0;
      non_ip_q <= '0;
      trunc_q  <= '0;
    end else begin
      if (beat_ok) begin
        hdr_q   <= hdr_d;
        ports_q <= ports_d;
        if (s_axis_tlast) begin
          state_q <= IDLE;
          off_q   <= '0;
        end else begin
          state_q <= PARSE;
          off_q   <= cnt_d;
        end
      end
      // A load on tlast takes priority over the drain in the same cycle.
      if (last_ok) begin
        valid_q  <= 1'b1;
        key_q    <= key_d;
        hash_q   <= hash_d;
        flags_q  <= flags_d;
        frames_q <= frames_q + 32'd1;
        if (!is_ip)
          non_ip_q <= non_ip_q + 32'd1;
        else if (is_trunc)
          trunc_q <= trunc_q + 32'd1;
      end else if (valid_q && m_key_ready) begin
        valid_q <= 1'b0;
        key_q   <= '0;
        hash_q  <= '0;
        flags_q <= '0;
      end
    end
  end

  assign m_key       = key_q;
  assign m_hash      = hash_q;
  assign m_flags     = flags_q;
  assign m_key_valid = valid_q;
  assign stat_frames = frames_q;
  assign stat_non_ip = non_ip_q;
  assign stat_trunc  = trunc_q;

endmodule

// File: tb/tb_flow_key_extractor.sv
// tb_flow_key_extractor
//   Scoreboard bench for flow_key_extractor (DATA_W=32, VLAN_EN=1). Directed
//   frames carry hand-derived expectations; random frames are scored by a
//   byte-array reference model. A negedge monitor pops and compares on every
//   output handshake and checks that a stalled slot holds stable.
module tb_flow_key_extractor;

  localparam int DW  = 32;
  localparam int NBT = DW / 8;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [103:0] key;
    logic [15:0]  hash;
    logic [3:0]   flags;
    int           frames;
    int           non_ip;
    int           trunc;
  } exp_t;

  logic           clk;
  logic           rst;
  logic [DW-1:0]  s_axis_tdata;
  logic [NBT-1:0] s_axis_tkeep;
  logic           s_axis_tvalid;
  logic           s_axis_tlast;
  logic           s_axis_tready;
  logic [103:0]   m_key;
  logic [15:0]    m_hash;
  logic [3:0]     m_flags;
  logic           m_key_valid;
  logic           m_key_ready;
  logic [31:0]    stat_frames, stat_non_ip, stat_trunc;

  flow_key_extractor #(.DATA_W(DW), .VLAN_EN(1'b1)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_key         (m_key),
    .m_hash        (m_hash),
    .m_flags       (m_flags),
    .m_key_valid   (m_key_valid),
    .m_key_ready   (m_key_ready),
    .stat_frames   (stat_frames),
    .stat_non_ip   (stat_non_ip),
    .stat_trunc    (stat_trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  int   ex_frames = 0, ex_non_ip = 0, ex_trunc = 0;
  bit   rand_en = 0;
  logic rdy_man = 1'b1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] hash_of(input logic [103:0] k);
    logic [111:0] w;
    logic [15:0]  h;
    w = {8'h00, k};
    h = '0;
    for (int i = 0; i < 7; i++) h = h ^ w[16*i +: 16];
    return h;
  endfunction

  function automatic bq_t build(input bit vl, input logic [15:0] et, input logic [7:0] vi,
                                input logic [15:0] frag, input logic [7:0] proto,
                                input logic [31:0] src, input logic [31:0] dst,
                                input logic [15:0] sp, input logic [15:0] dp, input int len);
    bq_t q;
    int  nopt;
    for (int i = 0; i < 12; i++) q.push_back(8'($urandom));
    if (vl) begin
      q.push_back(8'h81); q.push_back(8'h00); q.push_back(8'h00); q.push_back(8'h64);
    end
    q.push_back(et[15:8]); q.push_back(et[7:0]);
    q.push_back(vi);       q.push_back(8'h00); q.push_back(8'h00); q.push_back(8'h40);
    q.push_back(8'h12);    q.push_back(8'h34); q.push_back(frag[15:8]); q.push_back(frag[7:0]);
    q.push_back(8'h40);    q.push_back(proto); q.push_back(8'h00); q.push_back(8'h00);
    for (int i = 3; i >= 0; i--) q.push_back(src[8*i +: 8]);
    for (int i = 3; i >= 0; i--) q.push_back(dst[8*i +: 8]);
    nopt = (int'(vi[3:0]) > 5) ? (int'(vi[3:0]) - 5) * 4 : 0;
    for (int i = 0; i < nopt; i++) q.push_back(8'($urandom));
    q.push_back(sp[15:8]); q.push_back(sp[7:0]);
    q.push_back(dp[15:8]); q.push_back(dp[7:0]);
    while (q.size() > len) void'(q.pop_back());
    while (q.size() < len) q.push_back(8'($urandom));
    return q;
  endfunction

  // Reference: classify a whole frame from its byte array (bytes never
  // received read as zero, reception saturates at 127 bytes).
  function automatic void model(input bq_t f, output logic [103:0] k,
                                output logic [3:0] fl, output int cls);
    logic [7:0]  b [0:255];
    logic [31:0] sip, dip, prt;
    int          n, L, P, ihl;
    bit          vl, ok;
    for (int i = 0; i < 256; i++) b[i] = 8'h00;
    n = (f.size() > 127) ? 127 : f.size();
    for (int i = 0; i < n; i++) b[i] = f[i];
    vl  = (b[12] == 8'h81 && b[13] == 8'h00);
    L   = vl ? 18 : 14;
    ihl = int'(b[L][3:0]);
    k   = '0;
    fl  = '0;
    fl[2] = vl;
    if ({b[L-2], b[L-1]} != 16'h0800 || b[L][7:4] != 4'd4) begin
      cls = 1;
    end else begin
      fl[0] = 1'b1;
      if (ihl < 5 || n < L + 20) begin
        fl[3] = 1'b1;
        cls   = 2;
      end else begin
        cls = 0;
        P   = L + 4 * ihl;
        ok  = (b[L+9] == 8'd6 || b[L+9] == 8'd17) &&
              (({b[L+6], b[L+7]} & 16'h1FFF) == 16'h0) && (n >= P + 4);
        sip = {b[L+12], b[L+13], b[L+14], b[L+15]};
        dip = {b[L+16], b[L+17], b[L+18], b[L+19]};
        prt = ok ? {b[P], b[P+1], b[P+2], b[P+3]} : 32'h0;
        k   = {sip, dip, prt, b[L+9]};
        fl[1] = ok;
      end
    end
  endfunction

  task automatic push_exp(input logic [103:0] k, input logic [3:0] fl,
                          input logic [15:0] h, input int cls);
    exp_t e;
    ex_frames++;
    if (cls == 1) ex_non_ip++;
    if (cls == 2) ex_trunc++;
    e.key = k; e.hash = h; e.flags = fl;
    e.frames = ex_frames; e.non_ip = ex_non_ip; e.trunc = ex_trunc;
    sb.push_back(e);
  endtask

  task automatic wait_accept();
    int t  = 0;
    bit ok = 0;
    while (!ok) begin
      @(negedge clk);
      ok = s_axis_tready;
      @(posedge clk);
      #1;
      t++;
      if (!ok && t > 2000) begin
        checks++; failures++;
        $display("FAIL accept_timeout: got tready=0 for %0d cycles required 1", t);
        ok = 1;
      end
    end
  endtask

  task automatic send_beats(input bq_t f, input int max_beats);
    int n = f.size();
    int nbeats = (n + NBT - 1) / NBT;
    for (int b = 0; b < nbeats && b < max_beats; b++) begin
      for (int i = 0; i < NBT; i++) begin
        if (b * NBT + i < n) begin
          s_axis_tdata[8*i +: 8] = f[b * NBT + i];
          s_axis_tkeep[i]        = 1'b1;
        end else begin
          s_axis_tdata[8*i +: 8] = 8'($urandom);
          s_axis_tkeep[i]        = 1'b0;
        end
      end
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (b == nbeats - 1);
      wait_accept();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_frame(input bq_t f);
    send_beats(f, 100000);
  endtask

  task automatic set_rdy(input logic v);
    @(posedge clk);
    rdy_man = v;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    @(negedge clk);
    chk({tag, "_tready"}, s_axis_tready, 1);
    chk({tag, "_valid"},  m_key_valid, 0);
    chk({tag, "_key"},    m_key, 0);
    chk({tag, "_hash"},   m_hash, 0);
    chk({tag, "_flags"},  m_flags, 0);
    chk({tag, "_stats"},  {stat_frames, stat_non_ip, stat_trunc}, 0);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  // m_key_ready driver: random or manual, updated just after each edge.
  initial begin
    m_key_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_key_ready = rand_en ? 1'($urandom_range(0, 3) != 0) : rdy_man;
    end
  end

  // Monitor: compare on every handshake; a stalled slot must not change.
  logic         pv = 1'b0, pr = 1'b0;
  logic [103:0] pk = '0;
  exp_t         me;
  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", m_key_valid, 1);
        chk("hold_key", m_key, pk);
      end
      if (m_key_valid && m_key_ready) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_key: got %0h required no output", m_key);
        end else begin
          me = sb.pop_front();
          chk("key", m_key, me.key);
          chk("hash", m_hash, me.hash);
          chk("flags", m_flags, me.flags);
          chk("stats", {stat_frames, stat_non_ip, stat_trunc},
              {32'(me.frames), 32'(me.non_ip), 32'(me.trunc)});
        end
      end
      pv = m_key_valid;
      pr = m_key_ready;
      pk = m_key;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish required finish before timeout");
    $fatal(1, "watchdog");
  end

  localparam logic [103:0] K_TCP = 104'hC0A80101_C0A80102_D200_0050_06;

  initial begin
    bq_t          f, fb;
    logic [103:0] k;
    logic [3:0]   fl;
    int           cls, len;
    logic [15:0]  et, frag;
    logic [7:0]   vi, proto;

    rst = 1'b1;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset("por");

    // Held slot and a half-received frame must both be wiped by reset.
    set_rdy(0);
    f = build(0, 16'h0800, 8'h45, 16'h0, 8'h06, 32'hC0A80101, 32'hC0A80102, 16'hD200, 16'h0050, 64);
    send_frame(f);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("held_valid", m_key_valid, 1);
    do_reset();
    check_reset("rst_slot");
    send_beats(f, 3);
    do_reset();
    check_reset("rst_mid");
    set_rdy(1);

    f = build(0, 16'h0800, 8'h45, 16'h4000, 8'h06, 32'hC0A80101, 32'hC0A80102, 16'hD200, 16'h0050, 64);
    push_exp(K_TCP, 4'b0011, 16'h53D4, 0);
    send_frame(f);
    f = build(1, 16'h0800, 8'h45, 16'h0, 8'h06, 32'hC0A80101, 32'hC0A80102, 16'hD200, 16'h0050, 64);
    push_exp(K_TCP, 4'b0111, 16'h53D4, 0);
    send_frame(f);
    f = build(0, 16'h0806, 8'h45, 16'h0, 8'h06, 32'hC0A80101, 32'hC0A80102, 16'hD200, 16'h0050, 60);
    push_exp('0, 4'b0000, 16'h0, 1);
    send_frame(f);
    f = build(0, 16'h0800, 8'h45, 16'h0, 8'h06, 32'hC0A80101, 32'hC0A80102, 16'hD200, 16'h0050, 30);
    push_exp('0, 4'b1001, 16'h0, 2);
    send_frame(f);
    f = build(0, 16'h0800, 8'h46, 16'h0, 8'h11, 32'hC0A80101, 32'hC0A80102, 16'h1234, 16'h0035, 64);
    k = 104'hC0A80101_C0A80102_1234_0035_11;
    push_exp(k, 4'b0011, hash_of(k), 0);
    send_frame(f);
    f = build(0, 16'h0800, 8'h46, 16'h0010, 8'h11, 32'hC0A80101, 32'hC0A80102, 16'h1234, 16'h0035, 64);
    k = 104'hC0A80101_C0A80102_0000_0000_11;
    push_exp(k, 4'b0001, hash_of(k), 0);
    send_frame(f);
    // Back-to-back single-beat frames exercise reload-while-draining.
    for (int i = 0; i < 3; i++) begin
      f = build(0, 16'h0800, 8'h45, 16'h0, 8'h06, 32'h1, 32'h2, 16'h3, 16'h4, 4);
      push_exp('0, 4'b0000, 16'h0, 1);
      send_frame(f);
    end
    drain();

    // Backpressure: second frame's first beat stalls until ready pulses.
    set_rdy(0);
    f  = build(0, 16'h0800, 8'h45, 16'h0, 8'h06, 32'hC0A80101, 32'hC0A80102, 16'hD200, 16'h0050, 64);
    fb = build(0, 16'h0800, 8'h46, 16'h0, 8'h11, 32'h0A000001, 32'h0A000002, 16'hBEEF, 16'h0035, 48);
    push_exp(K_TCP, 4'b0011, 16'h53D4, 0);
    model(fb, k, fl, cls);
    push_exp(k, fl, hash_of(k), cls);
    send_frame(f);
    fork
      send_frame(fb);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_tready", s_axis_tready, 0);
          chk("bp_key", m_key, K_TCP);
        end
        set_rdy(1);
        set_rdy(0);
      end
    join
    @(negedge clk);
    chk("bp_second_valid", m_key_valid, 1);
    set_rdy(1);
    drain();

    // Random traffic under random output backpressure.
    rand_en = 1;
    for (int n = 0; n < 160; n++) begin
      et    = ($urandom_range(0, 9) < 8) ? 16'h0800 :
              (($urandom_range(0, 1) == 0) ? 16'h0806 : 16'($urandom));
      vi    = {(($urandom_range(0, 9) < 9) ? 4'd4 : 4'd6),
               (($urandom_range(0, 9) < 8) ? 4'(5 + $urandom_range(0, 2)) : 4'($urandom_range(0, 15)))};
      proto = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (($urandom_range(0, 1) == 0) ? 8'd6 : 8'd17);
      frag  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h4000;
      len   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : $urandom_range(34, 160);
      f = build(1'($urandom_range(0, 1)), et, vi, frag, proto, $urandom, $urandom,
                16'($urandom), 16'($urandom), len);
      model(f, k, fl, cls);
      push_exp(k, fl, hash_of(k), cls);
      send_frame(f);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rand_en = 0;
    set_rdy(1);
    drain();
    @(negedge clk);
    chk("final_frames", stat_frames, 32'(ex_frames));
    chk("final_non_ip", stat_non_ip, 32'(ex_non_ip));
    chk("final_trunc",  stat_trunc,  32'(ex_trunc));
    chk("final_idle",   m_key_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
